// File: rtl/bl_pair_reader_if.sv
// Interface bundling the sample-write, pair-read and status signals of bl_pair_reader.
// Ports: din/din_valid/din_sync (write side), rd_en/ant_a/ant_b/sel_a/sel_b (read request),
//        dout_a/dout_b/dout_valid/dout_ant_a/dout_ant_b (read result), wr_bank/collision (status).
`timescale 1ns/1ps
interface bl_pair_reader_if #(
    parameter int N_ANTS     = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int ANT_BITS = $clog2(N_ANTS);

    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_sync;
    logic                  rd_en;
    logic [ANT_BITS-1:0]   ant_a;
    logic [ANT_BITS-1:0]   ant_b;
    logic                  sel_a;
    logic                  sel_b;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  dout_valid;
    logic [ANT_BITS-1:0]   dout_ant_a;
    logic [ANT_BITS-1:0]   dout_ant_b;
    logic                  wr_bank;
    logic                  collision;

    // master: the sample source / baseline order generator side
    modport master (
        output din, din_valid, din_sync, rd_en, ant_a, ant_b, sel_a, sel_b,
        input  dout_a, dout_b, dout_valid, dout_ant_a, dout_ant_b, wr_bank, collision
    );

    // slave: the pair reader itself
    modport slave (
        input  din, din_valid, din_sync, rd_en, ant_a, ant_b, sel_a, sel_b,
        output dout_a, dout_b, dout_valid, dout_ant_a, dout_ant_b, wr_bank, collision
    );
endinterface

// File: rtl/bl_pair_reader.sv
// Double-banked antenna sample buffer: one write port, two read ports, read-first on collision.
// Latency: a pair requested with rd_en appears on dout_a/dout_b exactly 2 cycles later.
// Backpressure: none; a new pair is accepted every cycle and the write side never stalls.
// Ports: clk, rst (async active-high), bus (bl_pair_reader_if.slave).
// Optional macro BL_PAIR_READER_ANT_TAG_EN: carries ant_a/ant_b alongside the data to
// dout_ant_a/dout_ant_b; when undefined those outputs are tied to 0.
`timescale 1ns/1ps
module bl_pair_reader #(
    parameter int N_ANTS     = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    bl_pair_reader_if.slave bus
);
    localparam int ANT_BITS  = $clog2(N_ANTS);
    localparam int ADDR_BITS = ANT_BITS + 1;

    // Write-side pointer
    logic [ANT_BITS-1:0]   wr_addr_q, wr_addr_d, wr_addr_base;
    logic                  wr_bank_q, wr_bank_d, wr_bank_base;
    logic [ADDR_BITS-1:0]  wr_word;
    logic [ADDR_BITS-1:0]  rd_word_a, rd_word_b;
    logic                  hit;
    logic                  collision_q, collision_d;

    // Storage, addressed {bank, antenna}; deliberately not reset
    logic [DATA_WIDTH-1:0] mem_q [2*N_ANTS];

    // Read pipeline
    logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;
    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;
    logic                  dout_vld_q;

    always_comb begin
        // A sync in the same cycle as a write redirects that write to {0,0}
        wr_addr_base = bus.din_sync ? '0   : wr_addr_q;
        wr_bank_base = bus.din_sync ? 1'b0 : wr_bank_q;
        wr_word      = {wr_bank_base, wr_addr_base};
        wr_addr_d    = wr_addr_base;
        wr_bank_d    = wr_bank_base;
        if (bus.din_valid) begin
            wr_addr_d = wr_addr_base + 1'b1;
            if (wr_addr_base == ANT_BITS'(N_ANTS - 1)) begin
                wr_bank_d = ~wr_bank_base;
            end
        end
        rd_word_a   = {bus.sel_a, bus.ant_a};
        rd_word_b   = {bus.sel_b, bus.ant_b};
        hit         = bus.rd_en && bus.din_valid &&
                      ((rd_word_a == wr_word) || (rd_word_b == wr_word));
        // Sync clears the sticky flag outright
        collision_d = bus.din_sync ? 1'b0 : (collision_q | hit);
    end

    // Memory write and registered read; non-blocking semantics give read-first on a same-word hit
    always_ff @(posedge clk) begin
        if (bus.din_valid) begin
            mem_q[wr_word] <= bus.din;
        end
        if (bus.rd_en) begin
            rd_a_q <= mem_q[rd_word_a];
            rd_b_q <= mem_q[rd_word_b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            collision_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            dout_vld_q  <= 1'b0;
            dout_a_q    <= '0;
            dout_b_q    <= '0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            collision_q <= collision_d;
            s1_vld_q    <= bus.rd_en;
            dout_vld_q  <= s1_vld_q;
            // Output holds its last pair when no read is arriving
            if (s1_vld_q) begin
                dout_a_q <= rd_a_q;
                dout_b_q <= rd_b_q;
            end
        end
    end

`ifdef BL_PAIR_READER_ANT_TAG_EN
    logic [ANT_BITS-1:0] tag_a_s1_q, tag_b_s1_q;
    logic [ANT_BITS-1:0] tag_a_q, tag_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_a_s1_q <= '0;
            tag_b_s1_q <= '0;
            tag_a_q    <= '0;
            tag_b_q    <= '0;
        end else begin
            if (bus.rd_en) begin
                tag_a_s1_q <= bus.ant_a;
                tag_b_s1_q <= bus.ant_b;
            end
            if (s1_vld_q) begin
                tag_a_q <= tag_a_s1_q;
                tag_b_q <= tag_b_s1_q;
            end
        end
    end

    assign bus.dout_ant_a = tag_a_q;
    assign bus.dout_ant_b = tag_b_q;
`else
    assign bus.dout_ant_a = '0;
    assign bus.dout_ant_b = '0;
`endif

    assign bus.dout_a     = dout_a_q;
    assign bus.dout_b     = dout_b_q;
    assign bus.dout_valid = dout_vld_q;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.collision  = collision_q;
endmodule

// File: doc/bl_pair_reader.md
BL_PAIR_READER -- requirements
Module: bl_pair_reader

Interface
REQ-001 Parameter N_ANTS, default 16: antennas per window; power of two, at least 4; ANT_BITS = log2(N_ANTS).
REQ-002 Parameter DATA_WIDTH, default 8: bits per antenna sample word.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 din  input  DATA_WIDTH  antenna sample, arriving in antenna order 0..N_ANTS-1.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 din_sync  input  1  restarts the write side at antenna 0, bank 0.
REQ-008 rd_en  input  1  read request for the pair (ant_a, ant_b) from the baseline order generator.
REQ-009 ant_a, ant_b  input  ANT_BITS each  antenna indices to read.
REQ-010 sel_a, sel_b  input  1 each  bank to read for ant_a and for ant_b respectively.
REQ-011 dout_a, dout_b  output  DATA_WIDTH each  samples read for ant_a and for ant_b.
REQ-012 dout_valid  output  1  dout_a and dout_b are valid this cycle.
REQ-013 dout_ant_a, dout_ant_b  output  ANT_BITS each  indices aligned with dout (macro-gated, see Configuration).
REQ-014 wr_bank  output  1  bank currently being written.
REQ-015 collision  output  1  sticky flag: a read and a write hit the same bank word in the same cycle.

Function
REQ-016 Storage SHALL be 2*N_ANTS words, addressed {bank, antenna}, with one write port and two independent read ports.
REQ-017 Each cycle with din_valid=1 SHALL write din to {wr_bank, wr_addr} and increment wr_addr modulo N_ANTS.
REQ-018 When wr_addr wraps from N_ANTS-1 to 0, wr_bank SHALL toggle in the same cycle.
REQ-019 din_sync=1 SHALL set wr_addr=0 and wr_bank=0 and clear collision; a din_valid in the same cycle SHALL be written to address {0,0} and leave wr_addr=1.
REQ-020 rd_en=1 SHALL read {sel_a, ant_a} and {sel_b, ant_b}; the results appear on dout_a and dout_b exactly 2 cycles later, with dout_valid=1.
REQ-021 The read pipeline SHALL be two register stages: a registered memory read, then an output register; a new pair SHALL be accepted every cycle with no stalls.
REQ-022 With rd_en=0, dout_valid SHALL be 0 two cycles later; dout_a and dout_b SHALL hold their previous values.
REQ-023 ant_a equal to ant_b with sel_a equal to sel_b (autocorrelation) SHALL return the same word on both outputs.
REQ-024 A read and a write to the same word in the same cycle SHALL return the pre-write data (read-first) and set collision to 1.
REQ-025 collision SHALL stay 1 until rst or din_sync.

Reset
REQ-026 rst=1 SHALL asynchronously clear wr_addr, wr_bank, collision, dout_valid, dout_a, dout_b, dout_ant_a, dout_ant_b and both pipeline valid stages.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 rst asserted mid-stream SHALL discard any in-flight read; dout_valid SHALL stay 0 until 2 cycles after the first rd_en following rst deassertion.

Configuration
REQ-029 With macro BL_PAIR_READER_ANT_TAG_EN defined, ant_a and ant_b SHALL be pipelined alongside the data so that dout_ant_a and dout_ant_b align with dout_valid.
REQ-030 With BL_PAIR_READER_ANT_TAG_EN undefined, dout_ant_a and dout_ant_b SHALL be tied to 0 and no tag registers SHALL be built.

Verification
REQ-031 rst, din_sync, then write din=0x10..0x1F (N_ANTS=16) -> wr_bank goes 0->1 on the 16th write, wr_addr=0.
REQ-032 After REQ-031, rd_en with ant_a=3, sel_a=0, ant_b=7, sel_b=0 -> 2 cycles later dout_a=0x13, dout_b=0x17, dout_valid=1.
REQ-033 Back-to-back rd_en for 136 cycles (full triangle) -> 136 consecutive dout_valid=1 with correct data and tags (macro on).
REQ-034 Write to {1,5} and read of {1,5} in the same cycle -> dout returns the old value, collision=1; a later din_sync -> collision=0.
REQ-035 rst pulsed while 2 reads are in flight -> dout_valid=0 immediately and stays 0; the next rd_en gives valid 2 cycles later.
REQ-036 din_sync together with din_valid mid-bank (wr_addr=9, wr_bank=1) -> word written to {0,0}, next write goes to {0,1}.
